// File: rtl/mtx_pkg.sv
// Shared types and defaults for the streaming matrix transpose block.
// Build option MTX_TRANSPOSE_PINGPONG_EN selects the double-buffered variant.
package mtx_pkg;

   localparam int MTX_N = 5;
   localparam int MTX_W = 8;

   localparam logic MTX_MODE_COPY      = 1'b0;
   localparam logic MTX_MODE_TRANSPOSE = 1'b1;

   typedef enum logic {
      LOAD,
      DRAIN
   } mtx_state_e;

   function automatic int mtx_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mtx_buffer.sv
// NxN element register bank: one full row written per cycle,
// read back as a row (copy) or a column (transpose) chosen by rd_mode.
module mtx_buffer
   import mtx_pkg::*;
#(
   parameter int N  = MTX_N,
   parameter int W  = MTX_W,
   parameter int IW = mtx_idx_w(MTX_N)
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [IW-1:0]   wr_idx,
   input  logic [N*W-1:0]  wr_data,
   input  logic            rd_mode,
   input  logic [IW-1:0]   rd_idx,
   output logic [N*W-1:0]  rd_data
);

   logic [W-1:0] mem [N][N];

   // Row write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < N; c++) begin
            mem[wr_idx][c] <= wr_data[c*W +: W];
         end
      end
   end

   // Row or column read for output index rd_idx
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < N; c++) begin
         unique case (rd_mode)
            MTX_MODE_TRANSPOSE: rd_data[c*W +: W] = mem[c][rd_idx];
            MTX_MODE_COPY:      rd_data[c*W +: W] = mem[rd_idx][c];
            default:            rd_data[c*W +: W] = '0;
         endcase
      end
   end

endmodule

// File: rtl/mtx_transpose_stream.sv
// Streams an NxN matrix in by rows and back out as transpose or copy.
// Define MTX_TRANSPOSE_PINGPONG_EN for two buffers (load while draining).
module mtx_transpose_stream
   import mtx_pkg::*;
#(
   parameter int N = MTX_N,
   parameter int W = MTX_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mode,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_row,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*W-1:0]  out_row,
   output logic            out_last,
   output logic            busy
);

   localparam int          IW   = mtx_idx_w(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0]  wr_row;
   logic [IW-1:0]  rd_row;
   logic           in_fire;
   logic           out_fire;
   logic           wr_last;
   logic           rd_last;
   logic [N*W-1:0] rd_data;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign wr_last  = (wr_row == LAST);
   assign rd_last  = (rd_row == LAST);

`ifdef MTX_TRANSPOSE_PINGPONG_EN

   logic [1:0]     full_q;
   logic [1:0]     full_d;
   logic [1:0]     mode_q;
   logic           wr_sel;
   logic           rd_sel;
   logic [N*W-1:0] rd_data0;
   logic [N*W-1:0] rd_data1;

   mtx_buffer #(.N(N), .W(W), .IW(IW)) u_buf0 (
      .clk     (clk),
      .wr_en   (in_fire && !wr_sel),
      .wr_idx  (wr_row),
      .wr_data (in_row),
      .rd_mode (mode_q[0]),
      .rd_idx  (rd_row),
      .rd_data (rd_data0)
   );

   mtx_buffer #(.N(N), .W(W), .IW(IW)) u_buf1 (
      .clk     (clk),
      .wr_en   (in_fire && wr_sel),
      .wr_idx  (wr_row),
      .wr_data (in_row),
      .rd_mode (mode_q[1]),
      .rd_idx  (rd_row),
      .rd_data (rd_data1)
   );

   // Handshake flags and full-flag update; set and clear hit different buffers
   always_comb begin
      in_ready  = !full_q[wr_sel];
      out_valid = full_q[rd_sel];
      rd_data   = rd_sel ? rd_data1 : rd_data0;
      full_d    = full_q;
      if (in_fire && wr_last) begin
         full_d[wr_sel] = 1'b1;
      end
      if (out_fire && rd_last) begin
         full_d[rd_sel] = 1'b0;
      end
   end

   // Counters, selectors and per-buffer mode latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= '0;
         mode_q <= '0;
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_row <= '0;
         rd_row <= '0;
      end else begin
         full_q <= full_d;
         if (in_fire) begin
            if (wr_row == '0) begin
               mode_q[wr_sel] <= mode;
            end
            if (wr_last) begin
               wr_row <= '0;
               wr_sel <= !wr_sel;
            end else begin
               wr_row <= wr_row + 1'b1;
            end
         end
         if (out_fire) begin
            if (rd_last) begin
               rd_row <= '0;
               rd_sel <= !rd_sel;
            end else begin
               rd_row <= rd_row + 1'b1;
            end
         end
      end
   end

   assign busy = (wr_row != '0) || (|full_q);

`else

   mtx_state_e state_q;
   mtx_state_e state_d;
   logic       mode_q;

   mtx_buffer #(.N(N), .W(W), .IW(IW)) u_buf (
      .clk     (clk),
      .wr_en   (in_fire),
      .wr_idx  (wr_row),
      .wr_data (in_row),
      .rd_mode (mode_q),
      .rd_idx  (rd_row),
      .rd_data (rd_data)
   );

   // Load/drain sequencing and handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && wr_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && rd_last) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // State register, row counters and mode latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         mode_q  <= MTX_MODE_COPY;
         wr_row  <= '0;
         rd_row  <= '0;
      end else begin
         state_q <= state_d;
         if (in_fire) begin
            if (wr_row == '0) begin
               mode_q <= mode;
            end
            wr_row <= wr_last ? '0 : wr_row + 1'b1;
         end
         if (out_fire) begin
            rd_row <= rd_last ? '0 : rd_row + 1'b1;
         end
      end
   end

   assign busy = (wr_row != '0) || (state_q == DRAIN);

`endif

   assign out_row  = out_valid ? rd_data : '0;
   assign out_last = out_valid && rd_last;

endmodule

// File: tb/tb_mtx_transpose_stream.sv
// Directed bench for mtx_transpose_stream (N=5, W=8).
// Pingpong-only section runs when MTX_TRANSPOSE_PINGPONG_EN is defined.
module tb_mtx_transpose_stream;

   localparam int N = 5;
   localparam int W = 8;

`ifdef MTX_TRANSPOSE_PINGPONG_EN
   localparam logic PP = 1'b1;
`else
   localparam logic PP = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_row;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_row;
   logic           out_last;
   logic           busy;

   int vectors     = 0;
   int miscompares = 0;

   mtx_transpose_stream #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] row_in(input logic [7:0] base, input int r);
      logic [N*W-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++) begin
         v[c*W +: W] = base | 8'(r << 4) | 8'(c);
      end
      return v;
   endfunction

   function automatic logic [N*W-1:0] row_out(input logic [7:0] base, input int k,
                                              input logic tr);
      logic [N*W-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++) begin
         if (tr) v[c*W +: W] = base | 8'(c << 4) | 8'(k);
         else    v[c*W +: W] = base | 8'(k << 4) | 8'(c);
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_matrix(input logic [7:0] base, input logic m,
                              input logic toggle, input logic gap);
      for (int r = 0; r < N; r++) begin
         if (gap && r == 2) begin
            in_valid = 1'b0;
            in_row   = 40'hDE_ADBE_EF55;
            mode     = !m;
            tick();
            tick();
            chk("busy_in_gap", 64'(busy), 64'(1));
         end
         in_valid = 1'b1;
         in_row   = row_in(base, r);
         mode     = (r == 0) ? m : (toggle ? (((r % 2) == 1) ? !m : m) : m);
         chk("in_ready_load", 64'(in_ready), 64'(1));
         tick();
      end
      in_valid = 1'b0;
      in_row   = '0;
      chk("latency_out_valid", 64'(out_valid), 64'(1));
      chk("busy_loaded", 64'(busy), 64'(1));
   endtask

   task automatic drain(input logic [7:0] base, input logic tr,
                        input int stall_row, input int stall_n);
      int low;
      low = 0;
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (k == stall_row) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               chk("stall_out_row", 64'(out_row), 64'(row_out(base, k, tr)));
               chk("stall_out_valid", 64'(out_valid), 64'(1));
               chk("stall_in_ready", 64'(in_ready), 64'(PP));
               tick();
            end
            out_ready = 1'b1;
         end
         chk("out_valid", 64'(out_valid), 64'(1));
         chk("out_row", 64'(out_row), 64'(row_out(base, k, tr)));
         chk("out_last", 64'(out_last), 64'(k == N - 1));
         chk("in_ready_drain", 64'(in_ready), 64'(PP));
         if (!in_ready) low++;
         tick();
      end
      out_ready = 1'b0;
      chk("post_out_valid", 64'(out_valid), 64'(0));
      chk("post_out_row", 64'(out_row), 64'(0));
      chk("post_out_last", 64'(out_last), 64'(0));
      chk("post_in_ready", 64'(in_ready), 64'(1));
      chk("post_busy", 64'(busy), 64'(0));
      chk("in_ready_low_cycles", 64'(low), PP ? 64'(0) : 64'(N));
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      in_valid  = 1'b0;
      in_row    = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_row", 64'(out_row), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // transpose, with an in_valid gap carrying garbage
      send_matrix(8'h00, 1'b1, 1'b0, 1'b1);
      drain(8'h00, 1'b1, -1, 0);

      // copy, mode toggled after row 0
      send_matrix(8'h00, 1'b0, 1'b1, 1'b0);
      drain(8'h00, 1'b0, -1, 0);

      // transpose, mode toggled, 3-cycle stall on output row 2
      send_matrix(8'h80, 1'b1, 1'b1, 1'b0);
      drain(8'h80, 1'b1, 2, 3);

      // reset after 3 rows, then a fresh matrix
      for (int r = 0; r < 3; r++) begin
         in_valid = 1'b1;
         in_row   = row_in(8'h08, r);
         mode     = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      chk("partial_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_matrix(8'h80, 1'b1, 1'b0, 1'b0);
      drain(8'h80, 1'b1, -1, 0);

`ifdef MTX_TRANSPOSE_PINGPONG_EN
      out_ready = 1'b1;
      fork
         begin
            for (int m = 0; m < 4; m++) begin
               for (int r = 0; r < N; r++) begin
                  in_valid = 1'b1;
                  in_row   = row_in(8'(((m & 1) << 7) | ((m >> 1) << 3)), r);
                  mode     = 1'(m & 1);
                  chk("pp_in_ready", 64'(in_ready), 64'(1));
                  tick();
               end
            end
            in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 10) begin
               tick();
               w++;
            end
            chk("pp_first_valid", 64'(out_valid), 64'(1));
            chk("pp_first_latency", 64'(w), 64'(N));
            for (int m = 0; m < 4; m++) begin
               for (int k = 0; k < N; k++) begin
                  chk("pp_no_gap", 64'(out_valid), 64'(1));
                  chk("pp_out_row", 64'(out_row),
                      64'(row_out(8'(((m & 1) << 7) | ((m >> 1) << 3)), k, 1'(m & 1))));
                  chk("pp_out_last", 64'(out_last), 64'(k == N - 1));
                  tick();
               end
            end
         end
      join
      out_ready = 1'b0;
      chk("pp_done_valid", 64'(out_valid), 64'(0));
      chk("pp_done_busy", 64'(busy), 64'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mtx_transpose_stream.md
# mtx_transpose_stream

Parametrised, clocked successor to the combinational 5x5 transpose. Accepts an NxN matrix of W-bit elements as a stream of N rows over a valid/ready handshake. Buffers the matrix and emits N rows of either its transpose or an unmodified copy over a second valid/ready handshake. Sits between the matrix-source stage and the downstream matrix operators in the coprocessor datapath.

## Interface
- `N`, default 5: matrix dimension (rows = columns), N >= 2.
- `W`, default 8: element width in bits.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  1 = transpose, 0 = pass-through copy; sampled only on acceptance of row 0 of each matrix.
- `in_valid`  in  1  `in_row` holds a valid row.
- `in_ready`  out  1  block can accept a row this cycle.
- `in_row`  in  N*W  one input row; element c at `[c*W +: W]`.
- `out_valid`  out  1  `out_row` holds a valid output row.
- `out_ready`  in  1  downstream accepts `out_row` this cycle.
- `out_row`  out  N*W  one output row; element c at `[c*W +: W]`.
- `out_last`  out  1  high with `out_row` index N-1.
- `busy`  out  1  high while any matrix is buffered or in flight.

## Operation
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- Row counter `wr_row` runs 0..N-1 and wraps to 0 after the Nth accepted row. The row is written into buffer row `wr_row`.
- `mode` is latched into `mode_q` on acceptance of row 0. Changes to `mode` on later rows of the same matrix are ignored.
- Output row k:
  - transpose: element c = A[c][k].
  - copy: element c = A[k][c].
- Read counter `rd_row` runs 0..N-1. `out_last` = (`rd_row` == N-1) && `out_valid`.
- FSM states:
  - LOAD: `in_ready`=1, `out_valid`=0. On the Nth accept -> DRAIN.
  - DRAIN: `in_ready`=0, `out_valid`=1. On the output transfer with `out_last` -> LOAD, counters return to 0.
- `out_row` is combinational from buffer registers and `rd_row`. It is forced to 0 whenever `out_valid`=0.
- `out_row` must hold stable while `out_valid && !out_ready`.
- `busy` = (`wr_row` != 0) || (state == DRAIN).
- `in_row` is ignored when `in_valid`=0. `out_ready` is ignored when `out_valid`=0.
- Reset values: state LOAD, counters 0, `in_ready`=1, `out_valid`=0, `out_row`=0, `out_last`=0, `busy`=0. Buffer contents are not reset.
- Reset mid-matrix discards partial input and undrained output. The first row accepted after reset is row 0.

## Timing
- Latency: the first `out_valid` is seen the cycle after the Nth input transfer.
- Single-buffer throughput: minimum 2N cycles per matrix (N load, N drain).
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- Backpressure: `out_ready`=0 stalls `rd_row`. Input stays blocked until the drain completes.

## Configuration
- `MTX_TRANSPOSE_PINGPONG_EN` defined:
  - Two buffers with separate write and read selectors, each buffer with its own latched `mode_q`.
  - Input may load buffer B while buffer A drains. `in_ready` = 0 only when both buffers are full.
  - A simultaneous Nth input accept and final output transfer of the other buffer hands off in the same cycle with no bubble.
  - Sustained throughput: 1 row per cycle each way. Latency is unchanged.
- Not defined: single buffer, FSM exactly as above.

## Structure
- Package `mtx_pkg`:
  - defaults `MTX_N`=5, `MTX_W`=8;
  - state enum {LOAD, DRAIN};
  - mode constants `MTX_MODE_COPY`=0, `MTX_MODE_TRANSPOSE`=1.
- Sub-module `mtx_buffer`: NxN register bank with a row-write port and a row-or-column read port selected by mode. Instantiated once, or twice under `MTX_TRANSPOSE_PINGPONG_EN`.

## Test plan
- Reset -> `in_ready`=1, `out_valid`=0, `out_row`=0, `busy`=0.
- N=5, W=8, mode=1, rows r with element c = 8'h{r}{c} -> output row k element c = 8'h{c}{k}; `out_last` on the 5th output; `in_ready` low for exactly 5 cycles with `out_ready`=1.
- Same stimulus with mode=0 -> outputs identical to inputs. Toggling `mode` after row 0 has no effect.
- `out_ready` held 0 for 3 cycles on output row 2 -> `out_row` stable; no rows lost or duplicated; `in_ready` stays 0.
- `rst_n` pulsed low after 3 input rows -> subsequent 5 rows form a fresh matrix, correctly transposed.
- Pingpong build, `in_valid` and `out_ready` held 1 across 4 back-to-back matrices -> 20 consecutive output rows with no gap, each matrix correct.
